main_memory_responder: RTL and testbench
========================================

# main_memory_responder

Main-memory side of the cache/memory handshake. Accepts line-fill reads and single-word writes from the cache controller's memory port (memoryAccessM/readM/writeM). Serves them with fixed, parameterised latency from an internal word array and answers with a one-cycle memoryReadyM pulse. Includes a small posted-write buffer, because write-hit traffic arrives as single-cycle access pulses that are never held.

## Interface
- ADDR_W, 16, word-address width
- DATA_W, 32, word width
- WORDS_PER_LINE, 4, words per cache line (power of 2, ≥2)
- READ_LAT, 4, wait cycles before line transfer (≥1)
- WRITE_LAT, 3, wait cycles before array write (≥1)
- POST_DEPTH, 2, posted-write buffer entries (power of 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- memoryAccessM  in  1  request valid (level for held requests, 1-cycle pulse for posted writes)
- readM  in  1  line read
- writeM  in  1  word write
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- memoryReadyM  out  1  completion pulse
- rdata  out  DATA_W*WORDS_PER_LINE  fill line; word i at bits [i*DATA_W +: DATA_W]
- busy  out  1  state ≠ IDLE or post buffer non-empty
- overflow  out  1  sticky: write pulse dropped because buffer full

## Operation
- Array: 2^ADDR_W words, not reset. Line base = addr with low log2(WORDS_PER_LINE) bits zeroed.
- States: IDLE, WLAT, RLAT, RFILL, DONE, RELEASE.
- IDLE:
  - Post buffer non-empty → pop head into op registers, go WLAT.
  - Else memoryAccessM=1 → latch addr/wdata/op, go RLAT if readM else WLAT if writeM.
  - readM and writeM both high → read wins.
  - Access with neither set → ignored, stay IDLE.
- Capture while not IDLE: a rising edge of memoryAccessM (high now, low last cycle) with writeM=1 and readM=0 pushes {addr, wdata} to the post buffer.
  - Buffer full → entry dropped, overflow set.
  - A rising edge with readM is not stored; the requester holds it and IDLE takes it later.
  - Write pulse in IDLE while the buffer is non-empty → pushed, so write order is preserved.
- Ordering: posted writes drain before any held read is served (read-after-write coherent).
- WLAT: counts WRITE_LAT cycles; array[addr] ← wdata on the last cycle's edge → DONE.
- RLAT: counts READ_LAT cycles → RFILL.
- RFILL: one word per cycle, word index 0..WORDS_PER_LINE-1, from line base + index into the rdata shadow → DONE after the last word.
- DONE: memoryReadyM=1 for exactly one cycle. For reads, rdata is updated from the shadow at entry to DONE. Always → RELEASE.
- RELEASE: one cycle, memoryAccessM ignored (the completed request is still high here) → IDLE.
- rdata holds its value until the next read reaches DONE. Writes never alter rdata.

## Timing
- Reset values: memoryReadyM=0, rdata=0, busy=0, overflow=0, state IDLE, buffer empty, counters 0.
- rst mid-operation: aborts everything. A pending array write does not occur, buffered writes are discarded, and overflow clears.
- Cycle 0 is the cycle in which IDLE samples the request.
- Read: RLAT in cycles 1..READ_LAT; RFILL in READ_LAT+1..READ_LAT+WORDS_PER_LINE; memoryReadyM and new rdata in cycle READ_LAT+WORDS_PER_LINE+1 (9 with defaults).
- Write: memoryReadyM in cycle WRITE_LAT+1 (4 with defaults). The array holds the new value from that cycle.
- Back-to-back: earliest next acceptance is 2 cycles after DONE (via RELEASE).
- Posted writes pass through the same WLAT/DONE/RELEASE path and also pulse memoryReadyM; the requester ignores that pulse.
- Buffer push and pop in the same cycle are allowed. Push into a full buffer with a simultaneous pop succeeds, with no overflow.

## Test plan
- Reset then hold a read at addr 0x0012, array 0x10..0x13 = A0..A3 → memoryReadyM only in cycle 9; rdata = {A3,A2,A1,A0}; returns to IDLE by cycle 11.
- Held write of 0xDEADBEEF to 0x0040 → ready in cycle 4; a later read at 0x0041 returns word0 = 0xDEADBEEF.
- 1-cycle write pulses to 0x20 and 0x21 during a read's RLAT → both buffered; after read DONE/RELEASE they drain in order (ready at +4 each); then a held read of 0x20 returns the new data.
- Three write pulses during one busy read (POST_DEPTH=2) → third dropped, overflow=1 and sticky; first two written.
- readM and writeM both high with access → treated as read; array unchanged.
- rst asserted in RFILL cycle 6 → all outputs 0 the next cycle. A held access already high at reset, with access held high after reset releases, is accepted in IDLE as a fresh read.

Source files
------------

// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
//
// Main-memory side of the cache/memory handshake. Serves held line-fill reads
// and held single-word writes with fixed latency from an internal word array,
// and signals completion with a one-cycle memoryReadyM pulse. Single-cycle
// write pulses that arrive while the responder is busy are captured in a
// small posted-write FIFO. That FIFO drains ahead of any held request, so a
// read that follows a posted write sees the new data.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   memoryAccessM  in   request valid (held level, or 1-cycle pulse for posted writes)
//   readM          in   line read request
//   writeM         in   word write request
//   addr           in   word address [ADDR_W]
//   wdata          in   write data [DATA_W]
//   memoryReadyM   out  completion pulse (one cycle, state DONE)
//   rdata          out  fill line, word i at bits [i*DATA_W +: DATA_W]
//   busy           out  FSM not idle or posted-write FIFO non-empty
//   overflow       out  sticky: a write pulse was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module main_memory_responder #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int READ_LAT       = 4,
  parameter int WRITE_LAT      = 3,
  parameter int POST_DEPTH     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             memoryAccessM,
  input  logic                             readM,
  input  logic                             writeM,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                wdata,
  output logic                             memoryReadyM,
  output logic [DATA_W*WORDS_PER_LINE-1:0] rdata,
  output logic                             busy,
  output logic                             overflow
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int PTR_W   = (POST_DEPTH > 1) ? $clog2(POST_DEPTH) : 1;
  localparam int MAX_RW  = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int MAX_CNT = (MAX_RW > WORDS_PER_LINE) ? MAX_RW : WORDS_PER_LINE;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WLAT    = 3'd1,
    RLAT    = 3'd2,
    RFILL   = 3'd3,
    DONE    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [DATA_W-1:0]   op_wdata_q, op_wdata_d;
  logic                acc_prev_q;
  logic                overflow_q;

  // Posted-write FIFO
  logic [ADDR_W-1:0]   buf_addr_q [POST_DEPTH];
  logic [DATA_W-1:0]   buf_data_q [POST_DEPTH];
  logic [PTR_W-1:0]    head_q, tail_q;
  logic [PTR_W:0]      count_q;

  // Word array and fill datapath
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [DATA_W-1:0]   shadow_q [WORDS_PER_LINE];
  logic [DATA_W-1:0]   fill_word_q;
  logic [ADDR_W-1:0]   rd_addr;

  logic buf_empty, buf_full, acc_rise, push_req, push, pop, drop;
  logic mem_we, fill_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(POST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign buf_empty = (count_q == '0);
  assign buf_full  = (count_q == (PTR_W+1)'(POST_DEPTH));
  assign acc_rise  = memoryAccessM & ~acc_prev_q;
  // IDLE pops whenever anything is queued, so posted writes always go first.
  assign pop       = (state_q == IDLE) && !buf_empty;
  // In IDLE an empty FIFO lets a pulse be taken directly; a non-empty one
  // forces the pulse to queue behind older writes to keep write order.
  assign push_req  = acc_rise && writeM && !readM && ((state_q != IDLE) || !buf_empty);
  // A full FIFO still accepts the push when a pop frees the head slot.
  assign push      = push_req && (!buf_full || pop);
  assign drop      = push_req && buf_full && !pop;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!buf_empty) begin
          op_addr_d  = buf_addr_q[head_q];
          op_wdata_d = buf_data_q[head_q];
          state_d    = WLAT;
        end else if (memoryAccessM && readM) begin
          op_addr_d  = addr;
          op_wdata_d = wdata;
          state_d    = RLAT;
        end else if (memoryAccessM && writeM) begin
          op_addr_d  = addr;
          op_wdata_d = wdata;
          state_d    = WLAT;
        end
      end
      WLAT: begin
        if (cnt_q == CNT_W'(WRITE_LAT - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RLAT: begin
        if (cnt_q == CNT_W'(READ_LAT - 1)) begin
          cnt_d   = '0;
          state_d = RFILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RFILL: begin
        if (cnt_q == CNT_W'(WORDS_PER_LINE - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = (state_q == WLAT)  && (cnt_q == CNT_W'(WRITE_LAT - 1));
  assign fill_last = (state_q == RFILL) && (cnt_q == CNT_W'(WORDS_PER_LINE - 1));
  // The array read is registered, so the address is issued one cycle early
  // from the next word index: word k lands in fill_word_q during RFILL cycle k.
  assign rd_addr   = {op_addr_q[ADDR_W-1:OFF_W], cnt_d[OFF_W-1:0]};

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      acc_prev_q <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_addr_q  <= op_addr_d;
      op_wdata_q <= op_wdata_d;
      acc_prev_q <= memoryAccessM;
      if (drop) overflow_q <= 1'b1;
      if (push) tail_q <= ptr_inc(tail_q);
      if (pop)  head_q <= ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_addr_q[tail_q] <= addr;
      buf_data_q[tail_q] <= wdata;
    end
  end

  // Word array: registered read, write gated by reset so an aborted write
  // never lands.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[op_addr_q] <= op_wdata_q;
    fill_word_q <= mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (state_q == RFILL) shadow_q[cnt_q[OFF_W-1:0]] <= fill_word_q;
  end

  // rdata is updated once, at entry to DONE; the last word comes straight
  // from the read register since the shadow is written on the same edge.
  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_line
    logic [DATA_W-1:0] word_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        word_q <= '0;
      end else if (fill_last) begin
        word_q <= (gi == WORDS_PER_LINE - 1) ? fill_word_q : shadow_q[gi];
      end
    end
    assign rdata[gi*DATA_W +: DATA_W] = word_q;
  end

  assign memoryReadyM = (state_q == DONE);
  assign busy         = (state_q != IDLE) || !buf_empty;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_main_memory_responder
//
// Self-checking bench for main_memory_responder with default parameters.
// A table of held transactions (preload writes, reads, write-then-read,
// read+write collision) is applied in a loop; hand-written cycle sequences
// cover posted writes, FIFO overflow and reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_main_memory_responder;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int WPL = 4;
  localparam int LW  = DW * WPL;

  localparam logic [LW-1:0] LINE_10 = {32'hC0DE_0013, 32'hC0DE_0012, 32'hC0DE_0011, 32'hC0DE_0010};
  localparam logic [LW-1:0] LINE_40 = {32'hC0DE_0043, 32'hC0DE_0042, 32'hC0DE_0041, 32'hDEAD_BEEF};
  localparam logic [LW-1:0] LINE_20 = {32'hC0DE_0023, 32'hC0DE_0022, 32'h5000_0021, 32'h5000_0020};
  localparam logic [LW-1:0] LINE_30 = {32'hC0DE_0033, 32'hC0DE_0032, 32'h6000_0031, 32'h6000_0030};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          memoryAccessM = 1'b0;
  logic          readM = 1'b0;
  logic          writeM = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          memoryReadyM;
  logic [LW-1:0] rdata;
  logic          busy;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            exp_cyc;
    logic [LW-1:0] exp_line;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] bases[4];
  logic [AW-1:0] pa;
  int            rc, ra, rb;

  always #5 clk = ~clk;

  main_memory_responder #(
    .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL),
    .READ_LAT(4), .WRITE_LAT(3), .POST_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .memoryAccessM(memoryAccessM), .readM(readM), .writeM(writeM),
    .addr(addr), .wdata(wdata),
    .memoryReadyM(memoryReadyM), .rdata(rdata),
    .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drv(input logic acc, input logic rd, input logic wr,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    memoryAccessM = acc;
    readM         = rd;
    writeM        = wr;
    addr          = a;
    wdata         = d;
  endtask

  // Called at a negedge in IDLE. The request is held through DONE and
  // RELEASE, then dropped. Returns the ready cycle (-1 on timeout), the
  // ready level in the following cycle and busy two cycles after DONE.
  task automatic held(input logic rd, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int rdy, output int after,
                      output int bsy);
    drv(1'b1, rd, wr, a, d);
    rdy = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (memoryReadyM) begin
        rdy = c;
        break;
      end
    end
    @(negedge clk);
    after = int'(memoryReadyM);
    drv(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    bsy = int'(busy);
  endtask

  // Held read at cycle 0, then write pulses at cycles 2,4,6 while it is busy.
  task automatic pulse_seq(input string tag, input logic [AW-1:0] rd_a,
                           input logic [LW-1:0] exp_line, input logic [AW-1:0] wbase,
                           input logic [DW-1:0] dbase, input int npulse,
                           input logic exp_ovf);
    int rq[$];
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (memoryReadyM) rq.push_back(c);
      end
      if (c == 7)  chk({tag, "_ovf_mid"}, overflow, exp_ovf);
      if (c == 9)  chk({tag, "_rdata"}, rdata, exp_line);
      if (c == 10) chk({tag, "_busy_draining"}, busy, 1'b1);
      if (c == 23) begin
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_ovf_end"}, overflow, exp_ovf);
      end
      if (c == 0) begin
        drv(1'b1, 1'b1, 1'b0, rd_a, '0);
      end else if ((c == 2 || c == 4 || c == 6) && (c / 2 <= npulse)) begin
        drv(1'b1, 1'b0, 1'b1, wbase + AW'(c / 2 - 1), dbase + DW'(c / 2 - 1));
      end else begin
        drv(1'b0, 1'b0, 1'b0, '0, '0);
      end
    end
    chk({tag, "_ready_count"}, LW'(rq.size()), LW'(3));
    if (rq.size() == 3) begin
      chk({tag, "_ready0"}, LW'(rq[0]), LW'(9));
      chk({tag, "_ready1"}, LW'(rq[1]), LW'(15));
      chk({tag, "_ready2"}, LW'(rq[2]), LW'(21));
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    drv(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ready", memoryReadyM, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- table of held transactions ----------------
    bases[0] = 16'h0010;
    bases[1] = 16'h0020;
    bases[2] = 16'h0030;
    bases[3] = 16'h0040;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        pa = bases[b] + AW'(k);
        vecs.push_back('{1'b0, 1'b1, pa, 32'hC0DE_0000 | DW'(pa), 4, '0});
      end
    end
    vecs.push_back('{1'b1, 1'b0, 16'h0012, 32'h0,         9, LINE_10});
    vecs.push_back('{1'b0, 1'b1, 16'h0040, 32'hDEAD_BEEF, 4, LINE_10});
    vecs.push_back('{1'b1, 1'b0, 16'h0041, 32'h0,         9, LINE_40});
    vecs.push_back('{1'b1, 1'b1, 16'h0011, 32'hBADB_AD00, 9, LINE_10});
    vecs.push_back('{1'b1, 1'b0, 16'h0013, 32'h0,         9, LINE_10});

    for (int i = 0; i < vecs.size(); i++) begin
      held(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, rc, ra, rb);
      chk($sformatf("vec%0d_ready_cycle", i), LW'(rc), LW'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_ready_width", i), LW'(ra), LW'(0));
      chk($sformatf("vec%0d_busy_after", i), LW'(rb), LW'(0));
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_line);
      $display("vec %0d rd=%0b wr=%0b addr=%h ready@%0d rdata=%h", i,
               vecs[i].rd, vecs[i].wr, vecs[i].a, rc, rdata);
    end

    // ---------------- access with neither read nor write ----------------
    rc = 0;
    drv(1'b1, 1'b0, 1'b0, 16'h0010, 32'h1234_5678);
    repeat (6) begin
      @(negedge clk);
      if (busy || memoryReadyM) rc = 1;
    end
    drv(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("neither_ignored", LW'(rc), LW'(0));
    $display("seq neither: activity=%0d", rc);

    // ---------------- posted writes drain in order ----------------
    pulse_seq("post", 16'h0041, LINE_40, 16'h0020, 32'h5000_0020, 2, 1'b0);
    held(1'b1, 1'b0, 16'h0020, '0, rc, ra, rb);
    chk("post_readback_cycle", LW'(rc), LW'(9));
    chk("post_readback_rdata", rdata, LINE_20);
    $display("seq post: readback ready@%0d rdata=%h", rc, rdata);

    // ---------------- overflow: third pulse dropped ----------------
    pulse_seq("ovf", 16'h0010, LINE_10, 16'h0030, 32'h6000_0030, 3, 1'b1);
    held(1'b1, 1'b0, 16'h0032, '0, rc, ra, rb);
    chk("ovf_readback_cycle", LW'(rc), LW'(9));
    chk("ovf_readback_rdata", rdata, LINE_30);
    chk("ovf_sticky", overflow, 1'b1);
    $display("seq ovf: readback ready@%0d overflow=%0b", rc, overflow);

    // ---------------- reset during RFILL, read held across it ----------------
    begin
      int rq[$];
      for (int c = 0; c <= 19; c++) begin
        if (c > 0) begin
          @(negedge clk);
          if (memoryReadyM) rq.push_back(c);
        end
        if (c == 0) drv(1'b1, 1'b1, 1'b0, 16'h0010, '0);
        if (c == 6) rst = 1'b1;
        if (c == 7) begin
          chk("rfill_rst_ready", memoryReadyM, 1'b0);
          chk("rfill_rst_rdata", rdata, '0);
          chk("rfill_rst_busy", busy, 1'b0);
          chk("rfill_rst_overflow", overflow, 1'b0);
          rst = 1'b0;
        end
        if (c == 17) drv(1'b0, 1'b0, 1'b0, '0, '0);
        if (c == 18) chk("rfill_rst_busy_end", busy, 1'b0);
      end
      // Cycle 7 is the first un-reset IDLE cycle, so the read completes at 7+9.
      chk("rfill_rst_ready_count", LW'(rq.size()), LW'(1));
      if (rq.size() == 1) chk("rfill_rst_ready_cycle", LW'(rq[0]), LW'(16));
      chk("rfill_rst_rdata_after", rdata, LINE_10);
      $display("seq rst_rfill: ready pulses=%0d rdata=%h", rq.size(), rdata);
    end

    // ---------------- reset aborts pending and buffered writes ----------------
    begin
      int nrdy;
      nrdy = 0;
      for (int c = 0; c <= 4; c++) begin
        if (c > 0) begin
          @(negedge clk);
          if (memoryReadyM) nrdy++;
        end
        case (c)
          0:       drv(1'b1, 1'b0, 1'b1, 16'h0011, 32'h5555_5555);
          2:       drv(1'b1, 1'b0, 1'b1, 16'h0012, 32'h6666_6666);
          default: drv(1'b0, 1'b0, 1'b0, '0, '0);
        endcase
        if (c == 3) rst = 1'b1;
        if (c == 4) begin
          chk("wlat_rst_busy", busy, 1'b0);
          rst = 1'b0;
        end
      end
      chk("wlat_rst_no_ready", LW'(nrdy), LW'(0));
      @(negedge clk);
      held(1'b1, 1'b0, 16'h0010, '0, rc, ra, rb);
      chk("wlat_rst_read_cycle", LW'(rc), LW'(9));
      chk("wlat_rst_read_rdata", rdata, LINE_10);
      $display("seq rst_wlat: readback ready@%0d rdata=%h", rc, rdata);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
